// File: rtl/frogger_game_ctrl.sv
// rtl/frogger_game_ctrl.sv - lives, death/respawn sequencing and round outcome for the frogger game
module frogger_game_ctrl #(
   parameter int         NUM_CARS     = 8,
   parameter logic [2:0] LIVES        = 3'd3,
   parameter logic [7:0] DEATH_FRAMES = 8'd60,
   parameter logic [7:0] GRACE_FRAMES = 8'd30,
   parameter logic [10:0] GOAL_Y      = 11'd40
) (
   input  logic                frame_clk,
   input  logic                Reset,
   input  logic [NUM_CARS-1:0] Car_Collision,
   input  logic [10:0]         Frog_Y,
   input  logic                Start,
   output logic                win,
   output logic                lose,
   output logic                Frog_Respawn,
   output logic                Dying,
   output logic [2:0]          Lives_Left,
   output logic [7:0]          Rounds_Won
);

   typedef enum logic [2:0] {
      S_RESPAWN = 3'd0,
      S_PLAY    = 3'd1,
      S_DYING   = 3'd2,
      S_WIN     = 3'd3,
      S_LOSE    = 3'd4
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [7:0] grace_cnt;
   logic [7:0] grace_next;
   logic [7:0] death_cnt;
   logic [7:0] death_next;
   logic [2:0] lives_next;
   logic [7:0] rounds_next;
   logic       hit;
   logic       goal;

   assign hit  = |Car_Collision;
   assign goal = (Frog_Y <= GOAL_Y);

   // Next-state, counter and score decisions for the round sequence
   always_comb begin
      state_next  = state;
      grace_next  = grace_cnt;
      death_next  = death_cnt;
      lives_next  = Lives_Left;
      rounds_next = Rounds_Won;
      case (state)
         S_RESPAWN: begin
            grace_next = GRACE_FRAMES;
            state_next = S_PLAY;
         end
         S_PLAY: begin
            if (grace_cnt != 8'd0) begin
               // Collisions are ignored while the grace window runs, but
               // reaching home still counts.
               grace_next = grace_cnt - 8'd1;
               if (goal) begin
                  if (Rounds_Won != 8'hFF) rounds_next = Rounds_Won + 8'd1;
                  state_next = S_WIN;
               end
            end else if (hit) begin
               if (Lives_Left != 3'd0) lives_next = Lives_Left - 3'd1;
               death_next = DEATH_FRAMES - 8'd1;
               state_next = S_DYING;
            end else if (goal) begin
               if (Rounds_Won != 8'hFF) rounds_next = Rounds_Won + 8'd1;
               state_next = S_WIN;
            end
         end
         S_DYING: begin
            if (death_cnt == 8'd0) begin
               state_next = (Lives_Left == 3'd0) ? S_LOSE : S_RESPAWN;
            end else begin
               death_next = death_cnt - 8'd1;
            end
         end
         S_WIN: begin
            if (Start) state_next = S_RESPAWN;
         end
         S_LOSE: begin
            if (Start) begin
               state_next  = S_RESPAWN;
               lives_next  = LIVES;
               rounds_next = 8'd0;
            end
         end
         default: begin
            state_next = S_RESPAWN;
         end
      endcase
   end

   // State, counters, score and registered state-decoded outputs
   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state        <= S_RESPAWN;
         grace_cnt    <= 8'd0;
         death_cnt    <= 8'd0;
         Lives_Left   <= LIVES;
         Rounds_Won   <= 8'd0;
         win          <= 1'b0;
         lose         <= 1'b0;
         Dying        <= 1'b0;
         Frog_Respawn <= 1'b0;
      end else begin
         state        <= state_next;
         grace_cnt    <= grace_next;
         death_cnt    <= death_next;
         Lives_Left   <= lives_next;
         Rounds_Won   <= rounds_next;
         win          <= (state == S_WIN);
         lose         <= (state == S_LOSE);
         Dying        <= (state == S_DYING);
         Frog_Respawn <= (state == S_RESPAWN);
      end
   end

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// tb/tb_frogger_game_ctrl.sv - randomized scenario bench for frogger_game_ctrl
module tb_frogger_game_ctrl;

   localparam int GRACE = 30;
   localparam int DEATH = 60;
   localparam int LIVES = 3;

   logic        frame_clk = 1'b0;
   logic        Reset;
   logic [7:0]  Car_Collision;
   logic [10:0] Frog_Y;
   logic        Start;
   logic        win;
   logic        lose;
   logic        Frog_Respawn;
   logic        Dying;
   logic [2:0]  Lives_Left;
   logic [7:0]  Rounds_Won;

   int errors = 0;
   int checks = 0;
   int since = 0;
   int exp_lives = LIVES;
   int exp_rounds = 0;

   frogger_game_ctrl dut (
      .frame_clk     (frame_clk),
      .Reset         (Reset),
      .Car_Collision (Car_Collision),
      .Frog_Y        (Frog_Y),
      .Start         (Start),
      .win           (win),
      .lose          (lose),
      .Frog_Respawn  (Frog_Respawn),
      .Dying         (Dying),
      .Lives_Left    (Lives_Left),
      .Rounds_Won    (Rounds_Won)
   );

   // Frame clock
   always #5 frame_clk = ~frame_clk;

   // Watchdog so the run always ends
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // One frame; tracks edges elapsed since the last observed respawn pulse
   task automatic step();
      @(posedge frame_clk);
      #1;
      if (Frog_Respawn) since = 0;
      else since++;
   endtask

   // Advance until the next edge is edge number j after the respawn pulse
   task automatic wait_edge(input int j);
      while (since + 1 < j) step();
   endtask

   task automatic test_reset();
      Reset = 1'b1; Car_Collision = 8'h00; Frog_Y = 11'd400; Start = 1'b0;
      step(); step();
      checks++;
      if ({win, lose, Dying, Frog_Respawn, Lives_Left, Rounds_Won} !== {4'b0000, 3'(LIVES), 8'd0})
         $display("FAIL reset_state: got w%b l%b d%b r%b lives=%0d rounds=%0d required all 0, lives=%0d rounds=0",
                  win, lose, Dying, Frog_Respawn, Lives_Left, Rounds_Won, LIVES);
      else ;
      if ({win, lose, Dying, Frog_Respawn, Lives_Left, Rounds_Won} !== {4'b0000, 3'(LIVES), 8'd0}) errors++;
      Reset = 1'b0;
      step();
      checks++;
      if ({Frog_Respawn, win, lose, Dying} !== 4'b1000 || Lives_Left !== 3'(LIVES)) begin
         errors++;
         $display("FAIL reset_first_frame: got resp=%b w=%b l=%b d=%b lives=%0d required resp=1 others 0 lives=%0d",
                  Frog_Respawn, win, lose, Dying, Lives_Left, LIVES);
      end
      step();
      checks++;
      if (Frog_Respawn !== 1'b0) begin
         errors++;
         $display("FAIL reset_pulse_width: Frog_Respawn=%b on frame 2, required 0", Frog_Respawn);
      end
      exp_lives = LIVES;
      exp_rounds = 0;
   endtask

   task automatic test_win();
      for (int it = 0; it < 2; it++) begin
         int j;
         Frog_Y = 11'd41;
         // First pass reaches home inside the grace window, second after it
         j = (it == 0) ? $urandom_range(since + 1, GRACE) : $urandom_range(GRACE + 1, GRACE + 10);
         wait_edge(j);
         Frog_Y = 11'($urandom_range(0, 40));
         if (it == 1) Car_Collision = 8'h00;
         step();
         exp_rounds = (exp_rounds < 255) ? exp_rounds + 1 : 255;
         checks++;
         if (Rounds_Won !== 8'(exp_rounds)) begin
            errors++;
            $display("FAIL win_rounds[%0d]: Rounds_Won=%0d required %0d", it, Rounds_Won, exp_rounds);
         end
         Frog_Y = 11'd400;
         step();
         checks++;
         if (win !== 1'b1 || Lives_Left !== 3'(exp_lives)) begin
            errors++;
            $display("FAIL win_flag[%0d]: win=%b lives=%0d required win=1 lives=%0d", it, win, Lives_Left, exp_lives);
         end
         Start = 1'b1;
         step(); step();
         checks++;
         if (Frog_Respawn !== 1'b1 || win !== 1'b0 || Lives_Left !== 3'(exp_lives)) begin
            errors++;
            $display("FAIL win_restart[%0d]: resp=%b win=%b lives=%0d required resp=1 win=0 lives=%0d",
                     it, Frog_Respawn, win, Lives_Left, exp_lives);
         end
         begin
            int bad = 0;
            repeat (5) begin
               step();
               if (win || Frog_Respawn || Dying) bad++;
            end
            checks++;
            if (bad != 0) begin
               errors++;
               $display("FAIL start_held[%0d]: %0d frames with activity, required 0", it, bad);
            end
         end
         Start = 1'b0;
      end
   endtask

   task automatic test_saturation();
      Frog_Y = 11'd0; Start = 1'b1;
      repeat (800) step();
      Frog_Y = 11'd400;
      repeat (4) step();
      Start = 1'b0;
      exp_rounds = 255;
      checks++;
      if (Rounds_Won !== 8'(exp_rounds)) begin
         errors++;
         $display("FAIL rounds_saturate: Rounds_Won=%0d required %0d", Rounds_Won, exp_rounds);
      end
   endtask

   task automatic test_collision();
      int j;
      int n;
      Frog_Y = 11'd400; Car_Collision = 8'h00;
      j = $urandom_range(GRACE + 1, GRACE + 15);
      wait_edge(j);
      Car_Collision = 8'($urandom_range(1, 255));
      step();
      exp_lives--;
      checks++;
      if (Lives_Left !== 3'(exp_lives)) begin
         errors++;
         $display("FAIL hit_lives: Lives_Left=%0d required %0d", Lives_Left, exp_lives);
      end
      Car_Collision = 8'($urandom);
      step();
      checks++;
      if (Dying !== 1'b1) begin
         errors++;
         $display("FAIL hit_dying: Dying=%b required 1", Dying);
      end
      n = 1;
      for (int k = 0; k < 200 && Dying; k++) begin
         Car_Collision = 8'($urandom);
         step();
         if (Dying) n++;
      end
      Car_Collision = 8'h00;
      checks++;
      if (n != DEATH) begin
         errors++;
         $display("FAIL dying_length: Dying high %0d frames, required %0d", n, DEATH);
      end
      checks++;
      if (Frog_Respawn !== 1'b1 || Lives_Left !== 3'(exp_lives)) begin
         errors++;
         $display("FAIL dying_respawn: resp=%b lives=%0d required resp=1 lives=%0d", Frog_Respawn, Lives_Left, exp_lives);
      end
   endtask

   task automatic test_grace_hold();
      int n = 0;
      Frog_Y = 11'd400;
      Car_Collision = 8'($urandom_range(1, 255));
      while (!Dying && n < 200) begin
         step();
         n++;
      end
      exp_lives--;
      checks++;
      if (n != GRACE + 2 || Lives_Left !== 3'(exp_lives)) begin
         errors++;
         $display("FAIL grace_hold: Dying after %0d frames lives=%0d, required %0d frames lives=%0d",
                  n, Lives_Left, GRACE + 2, exp_lives);
      end
      Car_Collision = 8'h00;
      for (int k = 0; k < 200 && Dying; k++) step();
      checks++;
      if (Frog_Respawn !== 1'b1) begin
         errors++;
         $display("FAIL grace_hold_respawn: Frog_Respawn=%b required 1", Frog_Respawn);
      end
   endtask

   task automatic test_hit_vs_goal();
      int j;
      int n;
      int bad = 0;
      Frog_Y = 11'd400; Car_Collision = 8'h00;
      j = $urandom_range(GRACE + 1, GRACE + 10);
      wait_edge(j);
      Frog_Y = 11'd40; Car_Collision = 8'h01;
      step();
      exp_lives--;
      checks++;
      if (Lives_Left !== 3'(exp_lives) || Rounds_Won !== 8'(exp_rounds)) begin
         errors++;
         $display("FAIL hit_priority: lives=%0d rounds=%0d required lives=%0d rounds=%0d",
                  Lives_Left, Rounds_Won, exp_lives, exp_rounds);
      end
      Frog_Y = 11'd400; Car_Collision = 8'h00;
      step();
      checks++;
      if (Dying !== 1'b1 || win !== 1'b0) begin
         errors++;
         $display("FAIL hit_priority_state: Dying=%b win=%b required Dying=1 win=0", Dying, win);
      end
      n = 1;
      for (int k = 0; k < 200 && Dying; k++) begin
         step();
         if (Dying) n++;
      end
      checks++;
      if (n != DEATH || lose !== 1'b1 || Frog_Respawn !== 1'b0 || Lives_Left !== 3'd0) begin
         errors++;
         $display("FAIL lose_entry: dying=%0d lose=%b resp=%b lives=%0d required dying=%0d lose=1 resp=0 lives=0",
                  n, lose, Frog_Respawn, Lives_Left, DEATH);
      end
      repeat (10) begin
         Car_Collision = 8'($urandom);
         Frog_Y = 11'($urandom_range(0, 80));
         step();
         if (!lose || Frog_Respawn || win || Lives_Left != 3'd0) bad++;
      end
      Car_Collision = 8'h00; Frog_Y = 11'd400;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL lose_hold: %0d frames left LOSE, required 0", bad);
      end
      Start = 1'b1;
      step();
      exp_lives = LIVES;
      exp_rounds = 0;
      checks++;
      if (Lives_Left !== 3'(exp_lives) || Rounds_Won !== 8'(exp_rounds)) begin
         errors++;
         $display("FAIL lose_restart: lives=%0d rounds=%0d required lives=%0d rounds=%0d",
                  Lives_Left, Rounds_Won, exp_lives, exp_rounds);
      end
      step();
      Start = 1'b0;
      checks++;
      if (Frog_Respawn !== 1'b1 || lose !== 1'b0) begin
         errors++;
         $display("FAIL lose_respawn: resp=%b lose=%b required resp=1 lose=0", Frog_Respawn, lose);
      end
   endtask

   task automatic test_reset_mid_dying();
      Frog_Y = 11'd0;
      step();
      Frog_Y = 11'd400; Start = 1'b1;
      step(); step(); step();
      Start = 1'b0;
      exp_rounds++;
      wait_edge($urandom_range(GRACE + 1, GRACE + 5));
      Car_Collision = 8'($urandom_range(1, 255));
      step();
      Car_Collision = 8'h00;
      repeat ($urandom_range(2, 30)) step();
      checks++;
      if (Dying !== 1'b1 || Rounds_Won !== 8'(exp_rounds) || Lives_Left !== 3'(exp_lives - 1)) begin
         errors++;
         $display("FAIL mid_dying_setup: Dying=%b rounds=%0d lives=%0d required Dying=1 rounds=%0d lives=%0d",
                  Dying, Rounds_Won, Lives_Left, exp_rounds, exp_lives - 1);
      end
      Reset = 1'b1;
      step();
      exp_lives = LIVES;
      exp_rounds = 0;
      checks++;
      if ({win, lose, Dying, Frog_Respawn, Lives_Left, Rounds_Won} !== {4'b0000, 3'(exp_lives), 8'(exp_rounds)}) begin
         errors++;
         $display("FAIL mid_dying_reset: w%b l%b d%b r%b lives=%0d rounds=%0d required all 0 lives=%0d rounds=0",
                  win, lose, Dying, Frog_Respawn, Lives_Left, Rounds_Won, exp_lives);
      end
      step();
      Reset = 1'b0;
      step();
      checks++;
      if (Frog_Respawn !== 1'b1 || Dying !== 1'b0) begin
         errors++;
         $display("FAIL mid_dying_release: resp=%b Dying=%b required resp=1 Dying=0", Frog_Respawn, Dying);
      end
   endtask

   // Scenario sequence
   initial begin
      test_reset();
      test_win();
      test_saturation();
      test_collision();
      test_grace_hold();
      test_hit_vs_goal();
      test_reset_mid_dying();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
